// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: valid/ready handshake bundle carrying a control field and a payload.
// Ports: valid, ready, ctrl[CTRL_W], data[DATA_W]; master drives valid/ctrl/data, slave drives ready.
interface pipe_skid_reg_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;
  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with a two-entry skid buffer, flush and a saturating stall counter.
// Ports: CLK, RST (sync, active-high), flush; in_if (slave: upstream entries), out_if (master: downstream entries);
// stall_cnt counts cycles where an entry is presented but not taken.
module pipe_skid_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  pipe_skid_reg_if.slave        in_if,
  pipe_skid_reg_if.master       out_if,
  output logic [CNT_W-1:0]      stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, drain;
  assign in_if.ready  = state_q != FULL;
  assign out_if.valid = state_q != EMPTY;
  // main is zeroed on every transition into EMPTY, so it already reads as a bubble
  assign out_if.ctrl  = main_ctrl_q;
  assign out_if.data  = main_data_q;
  assign stall_cnt    = cnt_q;
  assign accept       = in_if.valid & in_if.ready;
  assign drain        = out_if.valid & out_if.ready;
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: if (accept) begin
        state_d     = ONE;
        main_ctrl_d = in_if.ctrl;
        main_data_d = in_if.data;
      end
      ONE: if (accept && drain) begin
        main_ctrl_d = in_if.ctrl;
        main_data_d = in_if.data;
      end else if (drain) begin
        state_d     = EMPTY;
        main_ctrl_d = '0;
        main_data_d = '0;
      end else if (accept) begin
        state_d     = FULL;
        skid_ctrl_d = in_if.ctrl;
        skid_data_d = in_if.data;
      end
      FULL: if (drain) begin
        state_d     = ONE;
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
        skid_ctrl_d = '0;
        skid_data_d = '0;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end
    cnt_d = (out_if.valid && !out_if.ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed stimulus with a scoreboard queue checked by an independent drain monitor.
module tb_pipe_skid_reg;
  localparam int CW = 16, DW = 128, NW = 4;
  logic CLK = 0, RST = 1, flush = 0;
  logic [NW-1:0] stall_cnt;
  logic [CW-1:0] exp_q[$];
  int tests = 0, fails = 0, drained = 0;
  pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) in_if ();
  pipe_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW)) out_if ();
  pipe_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_if(in_if), .out_if(out_if), .stall_cnt(stall_cnt)
  );
  always #5 CLK = ~CLK;
  function automatic logic [DW-1:0] pay(input logic [CW-1:0] c);
    return {8{c}};
  endfunction
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // drain monitor: an entry presented with out_ready high leaves at the coming edge
  always begin
    @(negedge CLK);
    #2;
    if (!RST && out_if.valid && out_if.ready) begin
      drained++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL drain_unexpected: got ctrl %0h expected no entry", out_if.ctrl);
      end else begin
        chk("drain_ctrl", DW'(out_if.ctrl), DW'(exp_q[0]));
        chk("drain_data", out_if.data, pay(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end
  // one cycle of stimulus; exp_* are the pre-edge outputs computed by hand
  task automatic step(input logic v, input logic [CW-1:0] c, input logic ordy, input logic fl,
                      input logic exp_ir, input logic exp_ov, input logic [CW-1:0] exp_oc,
                      input logic [NW-1:0] exp_cnt);
    @(negedge CLK);
    in_if.valid = v;
    in_if.ctrl = c;
    in_if.data = pay(c);
    out_if.ready = ordy;
    flush = fl;
    #1;
    chk("in_ready", DW'(in_if.ready), DW'(exp_ir));
    chk("out_valid", DW'(out_if.valid), DW'(exp_ov));
    chk("out_ctrl", DW'(out_if.ctrl), DW'(exp_oc));
    chk("out_data", out_if.data, exp_ov ? pay(exp_oc) : '0);
    chk("stall_cnt", DW'(stall_cnt), DW'(exp_cnt));
    if (v && exp_ir && !fl) exp_q.push_back(c);
    if (fl) begin
      #2;
      exp_q.delete();
    end
  endtask
  task automatic do_reset();
    @(negedge CLK);
    RST = 1;
    in_if.valid = 1;
    in_if.ctrl = 16'hFFFF;
    in_if.data = pay(16'hFFFF);
    out_if.ready = 0;
    flush = 0;
    repeat (2) @(negedge CLK);
    RST = 0;
    in_if.valid = 0;
    exp_q.delete();
  endtask
  initial begin
    in_if.valid = 0; in_if.ctrl = 0; in_if.data = 0; out_if.ready = 0;
    do_reset();
    step(0, 0, 0, 0, 1, 0, 0, 0);
    // streaming
    step(1, 1, 1, 0, 1, 0, 0, 0);
    step(1, 2, 1, 0, 1, 1, 1, 0);
    step(1, 3, 1, 0, 1, 1, 2, 0);
    step(1, 4, 1, 0, 1, 1, 3, 0);
    step(0, 0, 1, 0, 1, 1, 4, 0);
    step(0, 0, 1, 0, 1, 0, 0, 0);
    // backpressure: A main, B skid, C refused then taken
    step(1, 16'h11, 0, 0, 1, 0, 0, 0);
    step(1, 16'h22, 0, 0, 1, 1, 16'h11, 0);
    step(1, 16'h33, 0, 0, 0, 1, 16'h11, 1);
    step(1, 16'h33, 1, 0, 0, 1, 16'h11, 2);
    step(1, 16'h33, 1, 0, 1, 1, 16'h22, 2);
    step(0, 0, 1, 0, 1, 1, 16'h33, 2);
    step(0, 0, 0, 0, 1, 0, 0, 2);
    // flush in FULL with D offered
    step(1, 16'hA1, 0, 0, 1, 0, 0, 2);
    step(1, 16'hB2, 0, 0, 1, 1, 16'hA1, 2);
    step(0, 0, 0, 0, 0, 1, 16'hA1, 3);
    step(1, 16'hD4, 0, 1, 0, 1, 16'hA1, 4);
    step(0, 0, 0, 0, 1, 0, 0, 5);
    step(0, 0, 1, 0, 1, 0, 0, 5);
    // flush with concurrent drain in ONE; E offered in the flush cycle is dropped
    step(1, 16'hA5, 1, 0, 1, 0, 0, 5);
    step(1, 16'hE6, 1, 1, 1, 1, 16'hA5, 5);
    step(0, 0, 1, 0, 1, 0, 0, 5);
    step(0, 0, 1, 0, 1, 0, 0, 5);
    // saturation, survives flush, cleared by reset
    step(1, 16'h77, 0, 0, 1, 0, 0, 5);
    for (int i = 0; i < 20; i++)
      step(0, 0, 0, 0, 1, 1, 16'h77, NW'((5 + i > 15) ? 15 : 5 + i));
    step(0, 0, 0, 1, 1, 1, 16'h77, 15);
    step(0, 0, 0, 0, 1, 0, 0, 15);
    do_reset();
    step(0, 0, 0, 0, 1, 0, 0, 0);
    chk("drained_total", DW'(drained), DW'(8));
    chk("queue_empty", DW'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
